// File: rtl/fp_wire.sv
// Shared types and constants for the fp_unit result checker.
package fp_wire;

    localparam logic [63:0] FP_CANON_NAN32 = 64'h00000000_7FC00000;
    localparam logic [63:0] FP_CANON_NAN64 = 64'h7FF80000_00000000;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        nomask;
    } fp_chk_ref_type;

    typedef enum logic [2:0] {
        CHK_IDLE,
        CHK_RUN,
        CHK_DRAIN,
        CHK_DONE,
        CHK_FAIL
    } fp_chk_state_type;

    // A canonical NaN from the unit hides the payload/sign differences
    // that the reference model is free to produce.
    function automatic logic fp_chk_match(
        input fp_chk_ref_type entry,
        input logic [63:0]    calc,
        input logic [4:0]     calc_flags
    );
        logic [63:0] diff;
        diff = entry.result ^ calc;
        if (!entry.nomask) begin
            if (entry.fmt == 2'd0 && calc == FP_CANON_NAN32) begin
                diff[21:0]  = '0;
                diff[63:31] = '0;
            end else if (entry.fmt == 2'd1 && calc == FP_CANON_NAN64) begin
                diff[50:0] = '0;
                diff[63]   = 1'b0;
            end
        end
        return (diff == '0) && ((entry.flags ^ calc_flags) == '0);
    endfunction

endpackage

// File: rtl/fp_chk_fifo.sv
// In-order reference queue with a fall-through head entry.
module fp_chk_fifo
    import fp_wire::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  fp_chk_ref_type         din,
    output fp_chk_ref_type         head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fp_chk_ref_type mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/fp_result_checker.sv
// Scoreboard for fp_unit: queues issued references, compares completions,
// counts pass/fail, captures the first failure and reports end of test.
module fp_result_checker
    import fp_wire::*;
#(
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 32,
    parameter bit HALT_ON_FAIL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             chk_clear,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [63:0]      issue_data1,
    input  logic [63:0]      issue_data2,
    input  logic [63:0]      issue_data3,
    input  logic [63:0]      issue_result,
    input  logic [4:0]       issue_flags,
    input  logic [1:0]       issue_fmt,
    input  logic             issue_nomask,
    input  logic             res_valid,
    input  logic [63:0]      res_result,
    input  logic [4:0]       res_flags,
    input  logic             end_of_test,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_valid,
    output logic [63:0]      fail_data1,
    output logic [63:0]      fail_data2,
    output logic [63:0]      fail_data3,
    output logic [63:0]      fail_ref,
    output logic [63:0]      fail_calc,
    output logic [4:0]       fail_flags_ref,
    output logic [4:0]       fail_flags_calc,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        fp_chk_state_type state;
        logic [CNT_W-1:0] pass_count;
        logic [CNT_W-1:0] fail_count;
        logic             fail_valid;
        logic [63:0]      fail_data1;
        logic [63:0]      fail_data2;
        logic [63:0]      fail_data3;
        logic [63:0]      fail_ref;
        logic [63:0]      fail_calc;
        logic [4:0]       fail_flags_ref;
        logic [4:0]       fail_flags_calc;
        logic             err_overflow;
        logic             err_underflow;
    } reg_type;

    reg_type        r;
    reg_type        v;
    fp_chk_ref_type din;
    fp_chk_ref_type head;
    logic           full;
    logic           empty;
    logic [AW:0]    count;
    logic [AW:0]    count_next;
    logic           accept;
    logic           push;
    logic           pop;
    logic           match;

    assign din = '{
        data1:  issue_data1,
        data2:  issue_data2,
        data3:  issue_data3,
        result: issue_result,
        flags:  issue_flags,
        fmt:    issue_fmt,
        nomask: issue_nomask
    };

    fp_chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (chk_clear),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        v      = r;
        accept = (r.state == CHK_IDLE) || (r.state == CHK_RUN);
        pop    = res_valid && !empty && (r.state != CHK_FAIL);
        push   = issue_valid && accept && (!full || pop);
        match  = fp_chk_match(head, res_result, res_flags);
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        // Any issue not taken is either full-queue or out-of-run traffic.
        if (issue_valid && !push) v.err_overflow = 1'b1;
        if (res_valid && empty && r.state != CHK_FAIL)
            v.err_underflow = 1'b1;

        if (pop) begin
            if (match) begin
                if (!(&r.pass_count))
                    v.pass_count = r.pass_count + CNT_W'(1);
            end else begin
                if (!(&r.fail_count))
                    v.fail_count = r.fail_count + CNT_W'(1);
                if (!r.fail_valid) begin
                    v.fail_valid      = 1'b1;
                    v.fail_data1      = head.data1;
                    v.fail_data2      = head.data2;
                    v.fail_data3      = head.data3;
                    v.fail_ref        = head.result;
                    v.fail_calc       = res_result;
                    v.fail_flags_ref  = head.flags;
                    v.fail_flags_calc = res_flags;
                end
            end
        end

        unique case (r.state)
            CHK_IDLE: begin
                if (issue_valid)
                    v.state = end_of_test ? CHK_DRAIN : CHK_RUN;
                else if (end_of_test)
                    v.state = CHK_DONE;
            end
            CHK_RUN: begin
                if (end_of_test)
                    v.state = (empty && !push && !pop) ? CHK_DONE : CHK_DRAIN;
            end
            CHK_DRAIN: begin
                if (count_next == '0) v.state = CHK_DONE;
            end
            default: ;
        endcase

        if (pop && !match && HALT_ON_FAIL) v.state = CHK_FAIL;
        if (chk_clear) v = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r <= '0;
        else        r <= v;
    end

    assign issue_ready     = !full;
    assign busy            = (r.state == CHK_RUN) || (r.state == CHK_DRAIN);
    assign done            = (r.state == CHK_DONE);
    assign all_pass        = done && (r.fail_count == '0)
                             && !r.err_overflow && !r.err_underflow;
    assign pass_count      = r.pass_count;
    assign fail_count      = r.fail_count;
    assign fail_valid      = r.fail_valid;
    assign fail_data1      = r.fail_data1;
    assign fail_data2      = r.fail_data2;
    assign fail_data3      = r.fail_data3;
    assign fail_ref        = r.fail_ref;
    assign fail_calc       = r.fail_calc;
    assign fail_flags_ref  = r.fail_flags_ref;
    assign fail_flags_calc = r.fail_flags_calc;
    assign err_overflow    = r.err_overflow;
    assign err_underflow   = r.err_underflow;

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed and randomized bench for fp_result_checker with a queue-based
// reference model of the scoreboard.
module tb_fp_result_checker;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             chk_clear = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [63:0]      issue_data1 = '0;
    logic [63:0]      issue_data2 = '0;
    logic [63:0]      issue_data3 = '0;
    logic [63:0]      issue_result = '0;
    logic [4:0]       issue_flags = '0;
    logic [1:0]       issue_fmt = '0;
    logic             issue_nomask = 1'b0;
    logic             res_valid = 1'b0;
    logic [63:0]      res_result = '0;
    logic [4:0]       res_flags = '0;
    logic             end_of_test = 1'b0;
    logic             busy;
    logic             done;
    logic             all_pass;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic             fail_valid;
    logic [63:0]      fail_data1;
    logic [63:0]      fail_data2;
    logic [63:0]      fail_data3;
    logic [63:0]      fail_ref;
    logic [63:0]      fail_calc;
    logic [4:0]       fail_flags_ref;
    logic [4:0]       fail_flags_calc;
    logic             err_overflow;
    logic             err_underflow;

    always #5 clock = ~clock;

    fp_result_checker #(
        .DEPTH        (DEPTH),
        .CNT_W        (CNT_W),
        .HALT_ON_FAIL (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .chk_clear       (chk_clear),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_data1     (issue_data1),
        .issue_data2     (issue_data2),
        .issue_data3     (issue_data3),
        .issue_result    (issue_result),
        .issue_flags     (issue_flags),
        .issue_fmt       (issue_fmt),
        .issue_nomask    (issue_nomask),
        .res_valid       (res_valid),
        .res_result      (res_result),
        .res_flags       (res_flags),
        .end_of_test     (end_of_test),
        .busy            (busy),
        .done            (done),
        .all_pass        (all_pass),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .fail_valid      (fail_valid),
        .fail_data1      (fail_data1),
        .fail_data2      (fail_data2),
        .fail_data3      (fail_data3),
        .fail_ref        (fail_ref),
        .fail_calc       (fail_calc),
        .fail_flags_ref  (fail_flags_ref),
        .fail_flags_calc (fail_flags_calc),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
        logic [63:0] res;
        logic [4:0]  fl;
        logic [1:0]  fmt;
        logic        nm;
    } ref_t;

    ref_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        end_of_test = 1'b0;
        chk_clear   = 1'b0;
    endtask

    task automatic do_clear();
        quiet();
        chk_clear = 1'b1;
        tick();
        chk_clear = 1'b0;
        q.delete();
    endtask

    task automatic set_issue(input ref_t e);
        issue_valid  = 1'b1;
        issue_data1  = e.d1;
        issue_data2  = e.d2;
        issue_data3  = e.d3;
        issue_result = e.res;
        issue_flags  = e.fl;
        issue_fmt    = e.fmt;
        issue_nomask = e.nm;
    endtask

    task automatic set_res(input logic [63:0] c, input logic [4:0] f);
        res_valid  = 1'b1;
        res_result = c;
        res_flags  = f;
    endtask

    function automatic logic [63:0] canon(input logic [1:0] fm);
        return (fm == 2'd1) ? 64'h7FF8000000000000 : 64'h000000007FC00000;
    endfunction

    // Quiet NaN of the entry's format, judged on the IEEE fields.
    function automatic bit is_qnan(input ref_t e);
        if (e.fmt == 2'd0) return (e.res[30:23] == 8'hFF) && e.res[22];
        if (e.fmt == 2'd1) return (e.res[62:52] == 11'h7FF) && e.res[51];
        return 1'b0;
    endfunction

    function automatic bit model_match(input ref_t e, input logic [63:0] c,
                                       input logic [4:0] f);
        if (f !== e.fl) return 1'b0;
        if (c === e.res) return 1'b1;
        return !e.nm && is_qnan(e) && (c === canon(e.fmt));
    endfunction

    function automatic ref_t rnd_ref();
        ref_t e;
        e.d1  = {$urandom, $urandom};
        e.d2  = {$urandom, $urandom};
        e.d3  = {$urandom, $urandom};
        e.res = {$urandom, $urandom};
        e.fl  = 5'($urandom);
        e.fmt = 2'($urandom_range(0, 2));
        e.nm  = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1) begin
            if (e.fmt == 2'd0) e.res[30:22] = 9'h1FF;
            else if (e.fmt == 2'd1) e.res[62:51] = 12'hFFF;
        end
        return e;
    endfunction

    function automatic ref_t mk(input logic [63:0] r, input logic [4:0] f,
                                input logic [1:0] fm, input logic nm);
        ref_t e;
        e     = rnd_ref();
        e.res = r;
        e.fl  = f;
        e.fmt = fm;
        e.nm  = nm;
        return e;
    endfunction

    task automatic gen_calc(input ref_t h, input bit inj,
                            output logic [63:0] c, output logic [4:0] f);
        int k;
        int b;
        k = $urandom_range(0, 40);
        b = $urandom_range(0, 63);
        c = h.res;
        f = h.fl;
        if (inj && k == 0) c[b] = ~c[b];
        else if (inj && k == 1) f[b % 5] = ~f[b % 5];
        else if (inj && k == 2) c = canon((h.fmt == 2'd1) ? 2'd0 : 2'd1);
        else if (k < 20 && !h.nm && is_qnan(h)) c = canon(h.fmt);
    endtask

    initial begin
        ref_t        e, h, e2, fe;
        logic [63:0] c, fc;
        logic [4:0]  f, ff;
        int          mp, mf, issued;
        bit          halted, do_iss, do_res, inj;

        quiet();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_allpass", 64'(all_pass), 64'd0);
        chk("rst_pass", 64'(pass_count), 64'd0);
        chk("rst_fail", 64'(fail_count), 64'd0);
        chk("rst_fvalid", 64'(fail_valid), 64'd0);
        chk("rst_errs", 64'({err_overflow, err_underflow}), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);

        // f32 add that matches exactly
        do_clear();
        e = mk(64'h3F800000, 5'h00, 2'd0, 1'b0);
        set_issue(e);
        tick();
        quiet();
        chk("t1_busy", 64'(busy), 64'd1);
        set_res(64'h3F800000, 5'h00);
        tick();
        quiet();
        chk("t1_pass", 64'(pass_count), 64'd1);
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_allpass", 64'(all_pass), 64'd1);

        // f64 canonical NaN: masked pass, then exact-compare fail
        do_clear();
        e  = mk(64'h7FF8000000000123, 5'h10, 2'd1, 1'b0);
        e2 = mk(64'h7FF8000000000123, 5'h10, 2'd1, 1'b1);
        set_issue(e);
        tick();
        set_issue(e2);
        tick();
        quiet();
        set_res(64'h7FF8000000000000, 5'h10);
        tick();
        quiet();
        chk("t2_pass", 64'(pass_count), 64'd1);
        chk("t2_nofail", 64'(fail_valid), 64'd0);
        set_res(64'h7FF8000000000000, 5'h10);
        tick();
        quiet();
        chk("t2_fail", 64'(fail_count), 64'd1);
        chk("t2_fvalid", 64'(fail_valid), 64'd1);
        chk("t2_fref", fail_ref, 64'h7FF8000000000123);
        chk("t2_fcalc", fail_calc, 64'h7FF8000000000000);
        chk("t2_fd1", fail_data1, e2.d1);
        chk("t2_fd3", fail_data3, e2.d3);
        chk("t2_ffl", 64'({fail_flags_ref, fail_flags_calc}), 64'h210);
        chk("t2_halt", 64'({busy, done}), 64'd0);

        // fill to DEPTH, then push+pop at full
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            e = rnd_ref();
            set_issue(e);
            q.push_back(e);
            tick();
        end
        quiet();
        chk("t3_ready", 64'(issue_ready), 64'd0);
        e = rnd_ref();
        h = q.pop_front();
        set_issue(e);
        q.push_back(e);
        set_res(h.res, h.fl);
        tick();
        quiet();
        chk("t3_noovf", 64'(err_overflow), 64'd0);
        chk("t3_stillfull", 64'(issue_ready), 64'd0);
        chk("t3_pass", 64'(pass_count), 64'd1);
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t3_drain", 64'({busy, done}), 64'b10);
        for (int i = 0; i < DEPTH; i++) begin
            h = q.pop_front();
            set_res(h.res, h.fl);
            tick();
        end
        quiet();
        chk("t3_pass9", 64'(pass_count), 64'd9);
        chk("t3_done", 64'({done, all_pass}), 64'b11);

        // underflow, late issue, clear priority, eot in IDLE
        do_clear();
        set_res(64'h1234, 5'h0);
        tick();
        quiet();
        chk("t4_unf", 64'(err_underflow), 64'd1);
        chk("t4_cnt", 64'({pass_count, fail_count}), 64'd0);
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t4_done_err", 64'({done, all_pass}), 64'b10);
        set_issue(rnd_ref());
        tick();
        quiet();
        chk("t4_ovf_done", 64'({err_overflow, done}), 64'b11);
        chk_clear = 1'b1;
        set_issue(rnd_ref());
        tick();
        quiet();
        chk("t4_clr_prio", 64'({busy, err_overflow, err_underflow}), 64'd0);
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t4_eot_idle", 64'({done, all_pass}), 64'b11);

        // flags-only mismatch halts
        do_clear();
        for (int i = 0; i < 3; i++) begin
            e = rnd_ref();
            if (i == 0) e.fl = 5'h01;
            set_issue(e);
            q.push_back(e);
            tick();
        end
        quiet();
        h = q.pop_front();
        set_res(h.res, 5'h00);
        tick();
        quiet();
        chk("t5_fail", 64'(fail_count), 64'd1);
        chk("t5_state", 64'({busy, done}), 64'd0);
        chk("t5_ffl", 64'({fail_flags_ref, fail_flags_calc}), 64'h020);
        for (int i = 0; i < 2; i++) begin
            h = q.pop_front();
            set_res(h.res, h.fl);
            tick();
        end
        quiet();
        chk("t5_frozen", 64'({pass_count, fail_count}), 64'd1);

        // asynchronous reset in DRAIN with entries outstanding
        do_clear();
        for (int i = 0; i < 4; i++) begin
            e = rnd_ref();
            set_issue(e);
            q.push_back(e);
            tick();
        end
        quiet();
        h = q.pop_front();
        set_res(h.res, h.fl);
        tick();
        quiet();
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t6_drain", 64'({busy, pass_count}), {31'd0, 1'b1, 32'd1});
        reset = 1'b0;
        #2;
        q.delete();
        chk("t6_rst_cnt", 64'({pass_count, fail_count}), 64'd0);
        chk("t6_rst_st", 64'({busy, done, all_pass, fail_valid}), 64'd0);
        chk("t6_rst_err", 64'({err_overflow, err_underflow}), 64'd0);
        chk("t6_rst_rdy", 64'(issue_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        e = rnd_ref();
        set_issue(e);
        tick();
        quiet();
        set_res(e.res, e.fl);
        tick();
        quiet();
        end_of_test = 1'b1;
        tick();
        quiet();
        chk("t6_rerun", 64'({done, all_pass, pass_count}), {30'd0, 2'b11, 32'd1});

        // randomized runs against the queue model
        for (int run = 0; run < 10; run++) begin
            do_clear();
            mp = 0;
            mf = 0;
            issued = 0;
            halted = 1'b0;
            inj = (run % 2) == 1;
            fe = rnd_ref();
            fc = '0;
            ff = '0;
            for (int cyc = 0; cyc < 400 && issued < 24 && !halted; cyc++) begin
                quiet();
                do_res = (q.size() != 0) && ($urandom_range(0, 1) == 1);
                do_iss = (q.size() < DEPTH || do_res)
                         && ($urandom_range(0, 2) != 0);
                if (do_res) begin
                    h = q.pop_front();
                    gen_calc(h, inj, c, f);
                    set_res(c, f);
                    if (model_match(h, c, f)) mp++;
                    else begin
                        mf++;
                        halted = 1'b1;
                        fe = h;
                        fc = c;
                        ff = f;
                    end
                end
                if (do_iss) begin
                    e = rnd_ref();
                    set_issue(e);
                    q.push_back(e);
                    issued++;
                end
                tick();
                chk("r_pass", 64'(pass_count), 64'(mp));
                chk("r_fail", 64'(fail_count), 64'(mf));
            end
            quiet();
            if (!halted) begin
                end_of_test = 1'b1;
                tick();
                quiet();
                chk("r_eot", 64'(done), 64'(q.size() == 0));
            end
            for (int cyc = 0; cyc < 64 && q.size() != 0 && !halted; cyc++) begin
                quiet();
                h = q.pop_front();
                gen_calc(h, inj, c, f);
                set_res(c, f);
                if (model_match(h, c, f)) mp++;
                else begin
                    mf++;
                    halted = 1'b1;
                    fe = h;
                    fc = c;
                    ff = f;
                end
                tick();
                chk("r_dpass", 64'(pass_count), 64'(mp));
                chk("r_dfail", 64'(fail_count), 64'(mf));
            end
            quiet();
            if (halted) begin
                chk("r_fvalid", 64'(fail_valid), 64'd1);
                chk("r_fref", fail_ref, fe.res);
                chk("r_fcalc", fail_calc, fc);
                chk("r_fd2", fail_data2, fe.d2);
                chk("r_ffl", 64'({fail_flags_ref, fail_flags_calc}),
                    64'({fe.fl, ff}));
                chk("r_halt", 64'({busy, done}), 64'd0);
                set_res({$urandom, $urandom}, 5'($urandom));
                tick();
                quiet();
                chk("r_ignored", 64'({pass_count, fail_count}),
                    {32'(mp), 32'd1});
                chk("r_nounf", 64'(err_underflow), 64'd0);
            end else begin
                chk("r_done", 64'({done, all_pass, fail_valid}), 64'b110);
                chk("r_total", 64'(pass_count), 64'(issued));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
